// File: rtl/sm_fetch_pkg.sv
// ---------------------------------------------------------------------------
// sm_fetch_pkg
//
// Shared definitions for the schoolMIPS instruction prefetch unit:
//   - fetch_state_t : FSM encodings (FS_IDLE / FS_REQ / FS_DROP)
//   - SM_RESET_PC   : default word address fetched first after reset
//   - fetch_entry_t : one buffered {pc, instr} pair (64 bits)
//   - next_pc()     : sequential word-address increment, wraps modulo 2^32
// ---------------------------------------------------------------------------
package sm_fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] SM_RESET_PC = 32'h0;

    localparam int ENTRY_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Word addresses: 32'hFFFFFFFF rolls over to 0 by plain 32-bit overflow.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/sm_fetch_fifo.sv
// ---------------------------------------------------------------------------
// sm_fetch_fifo
//
// DEPTH-entry buffer of {pc, instr} pairs for the prefetch unit.
// The head entry is read straight out of the storage array, so the consumer
// never sees a combinational path from the write data.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (empties the buffer)
//   push       in   write push_data at the tail
//   push_data  in   64-bit {pc, instr} entry
//   pop        in   drop the head entry (ignored when empty)
//   flush      in   empty the buffer; wins over push and pop
//   head       out  entry at the head (stale/don't-care when count == 0)
//   count      out  number of valid entries, 0..DEPTH
//   full       out  count == DEPTH
// ---------------------------------------------------------------------------
module sm_fetch_fifo
    import sm_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [ENTRY_W-1:0]      push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [ENTRY_W-1:0]      head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && (count != '0);
    // A push into a full buffer is accepted only when the head leaves the
    // same cycle, so the entry count never exceeds DEPTH.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; only the pointers and count
    // decide which entries are valid, so clearing the data would be wasted
    // logic and would stop the array mapping onto plain RAM/registers.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sm_fetch.sv
// ---------------------------------------------------------------------------
// sm_fetch
//
// Instruction prefetch unit between the schoolMIPS core and a bus-attached
// instruction memory with variable wait states. Issues sequential word reads
// ahead of the core, buffers up to DEPTH {pc, instr} pairs and presents the
// buffer head with a valid/taken handshake. A redirect flushes the buffer and
// restarts fetching at redirectPc; a read already on the bus is completed and
// its data dropped (FS_DROP), since the bus request must stay stable until ack.
//
// Optional feature (macro SM_FETCH_BYPASS_EN): when the buffer is empty and a
// read completes without a redirect, memData/memAddr drive instr/instrPc
// combinationally that same cycle; if the core takes it, it is not buffered.
// With the macro undefined all core-facing outputs come from registers.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset, priority over everything
//   redirect    in   core requests a non-sequential fetch restart
//   redirectPc  in   word address for restart, valid with redirect
//   instrValid  out  head holds a valid instruction
//   instr       out  head instruction word
//   instrPc     out  word address of head instruction
//   instrTaken  in   core consumes head this cycle (ignored if !instrValid)
//   memReq      out  read request to instruction memory
//   memAddr     out  word address of request
//   memAck      in   read completes this cycle
//   memData     in   read data, valid with memAck
// ---------------------------------------------------------------------------
module sm_fetch
    import sm_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = SM_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    input  logic        instrTaken,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [31:0]        fetch_pc_q;
    logic [31:0]        fetch_pc_d;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_addr_d;

    logic               push;
    logic               pop;
    logic               flush;
    logic               head_valid;
    logic               bypass_hit;
    logic               bypass_taken;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      count_next;
    logic               fifo_full;
    logic [ENTRY_W-1:0] fifo_head;
    fetch_entry_t       head_entry;

    sm_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({mem_addr_q, memData}),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign head_entry = fetch_entry_t'(fifo_head);
    assign head_valid = (fifo_count != '0);

`ifdef SM_FETCH_BYPASS_EN
    assign bypass_hit   = (state_q == FS_REQ) && memAck && !redirect && !head_valid;
    assign bypass_taken = bypass_hit && instrTaken;
`else
    assign bypass_hit   = 1'b0;
    assign bypass_taken = 1'b0;
`endif

    assign instrValid = head_valid || bypass_hit;
    assign instr      = bypass_hit ? memData    : head_entry.instr;
    assign instrPc    = bypass_hit ? mem_addr_q : head_entry.pc;

    // A request is on the bus in every state but IDLE; memAddr is a register
    // so it holds stable until the ack cycle.
    assign memReq  = (state_q != FS_IDLE);
    assign memAddr = mem_addr_q;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    // Blocking assignments are correct in combinational logic: count_next
    // must see the push value decided just above it.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        count_next = fifo_count;
        // Redirect empties the buffer on the same edge and wins over taken.
        flush      = redirect;
        pop        = instrTaken && head_valid && !redirect;

        unique case (state_q)
            FS_IDLE: begin
                if (redirect) begin
                    // Buffer is flushed, so there is room: start at once.
                    fetch_pc_d = redirectPc;
                    mem_addr_d = redirectPc;
                    state_d    = FS_REQ;
                end else if (!fifo_full) begin
                    mem_addr_d = fetch_pc_q;
                    state_d    = FS_REQ;
                end
            end

            FS_REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirectPc;
                    if (memAck) begin
                        // Acked word belongs to the old stream: drop it.
                        mem_addr_d = redirectPc;
                    end else begin
                        // Bus request cannot be withdrawn; wait it out.
                        state_d = FS_DROP;
                    end
                end else if (memAck) begin
                    push       = !bypass_taken;
                    fetch_pc_d = next_pc(fetch_pc_q);
                    mem_addr_d = next_pc(fetch_pc_q);
                    // Issuing the next request needs a free slot for it.
                    count_next = fifo_count + CW'(push) - CW'(pop);
                    if (count_next >= DEPTH_C) begin
                        state_d = FS_IDLE;
                    end
                end
            end

            FS_DROP: begin
                if (redirect) begin
                    fetch_pc_d = redirectPc;
                end
                if (memAck) begin
                    mem_addr_d = redirect ? redirectPc : fetch_pc_q;
                    state_d    = FS_REQ;
                end
            end

            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_sm_fetch.sv
// ---------------------------------------------------------------------------
// tb_sm_fetch
//
// Directed bench for sm_fetch (DEPTH=4, RESET_PC=0, default build).
// Each cycle is described by a vector of core/memory inputs and the outputs
// expected during that cycle. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge. The memory acks only while
// memReq is high and returns word_of(memAddr).
// ---------------------------------------------------------------------------
module tb_sm_fetch;

    typedef struct {
        logic        chk;
        logic        rst;
        logic        redirect;
        logic [31:0] rpc;
        logic        taken;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrTaken;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;

    int checks   = 0;
    int failures = 0;
    int cyc_idx  = 0;

    vec_t vecs[$];

    sm_fetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .instrValid (instrValid),
        .instr      (instr),
        .instrPc    (instrPc),
        .instrTaken (instrTaken),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memData    (memData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic vec_t mk(input logic r, input logic redir, input logic [31:0] rpc,
                                input logic taken, input logic ack,
                                input logic req, input logic [31:0] addr,
                                input logic valid, input logic [31:0] pc);
        vec_t v;
        v.chk       = 1'b1;
        v.rst       = r;
        v.redirect  = redir;
        v.rpc       = rpc;
        v.taken     = taken;
        v.ack       = ack;
        v.exp_req   = req;
        v.exp_addr  = addr;
        v.exp_valid = valid;
        v.exp_pc    = pc;
        return v;
    endfunction

    function automatic vec_t mk_rst();
        vec_t v;
        v = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        v.chk = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0d: got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        rst        = v.rst;
        redirect   = v.redirect;
        redirectPc = v.rpc;
        instrTaken = v.taken;
        memAck     = v.ack && (memReq === 1'b1);
        memData    = memAck ? word_of(memAddr) : 32'hDEAD_BEEF;
        @(negedge clk);
        if (v.chk) begin
            check({name, ".memReq"}, cyc_idx, {31'd0, memReq}, {31'd0, v.exp_req});
            if (v.exp_req) begin
                check({name, ".memAddr"}, cyc_idx, memAddr, v.exp_addr);
            end
            check({name, ".instrValid"}, cyc_idx, {31'd0, instrValid}, {31'd0, v.exp_valid});
            if (v.exp_valid) begin
                check({name, ".instrPc"}, cyc_idx, instrPc, v.exp_pc);
                check({name, ".instr"}, cyc_idx, instr, word_of(v.exp_pc));
            end
        end
        cyc_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        cyc_idx = 0;
        run_vec(mk_rst(), name);
        run_vec(mk_rst(), name);
        cyc_idx = 0;
    endtask

    initial begin
        rst        = 1'b1;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        instrTaken = 1'b0;
        memAck     = 1'b0;
        memData    = 32'h0;
        @(posedge clk);
        #1;

        // ---- table: streaming with taken=1, then fill-to-full with taken=0
        //      args: rst redir rpc taken ack | req addr valid pc
        vecs.push_back(mk_rst());
        vecs.push_back(mk_rst());
        vecs.push_back(mk(0, 0, 0, 1, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,  1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,  1, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1,  1, 3, 1, 2));
        vecs.push_back(mk_rst());
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 1));
        // in-flight ack plus taken with count+outstanding == DEPTH
        vecs.push_back(mk(0, 0, 0, 1, 1,  1, 4, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 5, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 2));

        cyc_idx = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], "tbl");
        end

        // ---- redirect while addr 5 waits on a 3-cycle memory
        do_reset("drop");
        run_vec(mk(0, 0, 0,     1, 1,  0, 0,     0, 0), "drop");
        run_vec(mk(0, 0, 0,     1, 1,  1, 0,     0, 0), "drop");
        run_vec(mk(0, 0, 0,     1, 1,  1, 1,     1, 0), "drop");
        run_vec(mk(0, 0, 0,     1, 1,  1, 2,     1, 1), "drop");
        run_vec(mk(0, 0, 0,     1, 1,  1, 3,     1, 2), "drop");
        run_vec(mk(0, 0, 0,     1, 1,  1, 4,     1, 3), "drop");
        run_vec(mk(0, 0, 0,     1, 0,  1, 5,     1, 4), "drop");
        run_vec(mk(0, 1, 'h40,  0, 0,  1, 5,     0, 0), "drop");
        run_vec(mk(0, 0, 0,     0, 0,  1, 5,     0, 0), "drop");
        run_vec(mk(0, 0, 0,     0, 1,  1, 5,     0, 0), "drop");
        run_vec(mk(0, 0, 0,     1, 1,  1, 'h40,  0, 0), "drop");
        run_vec(mk(0, 0, 0,     1, 1,  1, 'h41,  1, 'h40), "drop");
        run_vec(mk(0, 0, 0,     1, 1,  1, 'h42,  1, 'h41), "drop");

        // ---- redirect + memAck + instrTaken in one cycle
        do_reset("redir_ack");
        run_vec(mk(0, 0, 0,     0, 1,  0, 0,     0, 0), "redir_ack");
        run_vec(mk(0, 0, 0,     0, 1,  1, 0,     0, 0), "redir_ack");
        run_vec(mk(0, 0, 0,     0, 1,  1, 1,     1, 0), "redir_ack");
        run_vec(mk(0, 1, 'h10,  1, 1,  1, 2,     1, 0), "redir_ack");
        run_vec(mk(0, 0, 0,     0, 0,  1, 'h10,  0, 0), "redir_ack");
        run_vec(mk(0, 0, 0,     0, 1,  1, 'h10,  0, 0), "redir_ack");
        run_vec(mk(0, 0, 0,     0, 0,  1, 'h11,  1, 'h10), "redir_ack");

        // ---- redirect from IDLE near the top of the address space: wrap,
        //      memReq at t+1 and instrValid at t+2
        do_reset("wrap");
        run_vec(mk(0, 1, 32'hFFFF_FFFE, 1, 1,  0, 0,            0, 0), "wrap");
        run_vec(mk(0, 0, 0,             1, 1,  1, 32'hFFFF_FFFE, 0, 0), "wrap");
        run_vec(mk(0, 0, 0,             1, 1,  1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE), "wrap");
        run_vec(mk(0, 0, 0,             1, 1,  1, 32'h0,         1, 32'hFFFF_FFFF), "wrap");
        run_vec(mk(0, 0, 0,             1, 1,  1, 32'h1,         1, 32'h0), "wrap");

        // ---- reset asserted for one cycle while in DROP
        do_reset("rst_drop");
        run_vec(mk(0, 1, 'h20,  0, 0,  0, 0,     0, 0), "rst_drop");
        run_vec(mk(0, 0, 0,     0, 0,  1, 'h20,  0, 0), "rst_drop");
        run_vec(mk(0, 1, 'h80,  0, 0,  1, 'h20,  0, 0), "rst_drop");
        run_vec(mk(1, 0, 0,     0, 0,  1, 'h20,  0, 0), "rst_drop");
        run_vec(mk(0, 0, 0,     0, 0,  0, 0,     0, 0), "rst_drop");
        run_vec(mk(0, 0, 0,     0, 1,  1, 0,     0, 0), "rst_drop");
        run_vec(mk(0, 0, 0,     0, 0,  1, 1,     1, 0), "rst_drop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
